// File: rtl/weave_row_if.sv
// Handshake and playback bundle between the pattern source / loom controller
// and weave_row_sequencer. The controller side uses master, the sequencer uses slave.
interface weave_row_if #(
  parameter int DEPTH = 8,
  parameter int W     = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic             start;
  logic             clear;
  logic             pick;
  logic [W-1:0]     row_out;
  logic             row_valid;
  logic [IDX_W-1:0] row_idx;
  logic [7:0]       repeat_cnt;
  logic             playing;

  modport master (
    output in_data, in_valid, start, clear, pick,
    input  in_ready, row_out, row_valid, row_idx, repeat_cnt, playing
  );

  modport slave (
    input  in_data, in_valid, start, clear, pick,
    output in_ready, row_out, row_valid, row_idx, repeat_cnt, playing
  );
endinterface

// File: rtl/weave_row_sequencer.sv
// Captures up to DEPTH lift rows, then replays them cyclically one row per pick.
// Define WEAVE_TWILL_SHIFT_EN to rotate the pattern left by one thread on every repeat.
module weave_row_sequencer #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  weave_row_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ROT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nx;
  logic [IDX_W-1:0] rd_ptr_q;
  logic [ROT_W-1:0] rot_q;
  logic [7:0]       repeat_q;
  logic [W-1:0]     row_out_p0;
  logic [IDX_W-1:0] row_idx_p0;
  logic             vld_p0;
  logic             wr_go;
  logic             start_go;
  logic             pick_go;
  logic             wrap;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROT_W-1:0] r);
    logic [2*W-1:0] d;
    d = {x, x} << r;
    return d[2*W-1:W];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef WEAVE_TWILL_SHIFT_EN
  function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] r);
    return (r == ROT_W'(W - 1)) ? '0 : r + ROT_W'(1);
  endfunction
`endif

  assign bus.in_ready = (state_q != PLAY) && (count_q < CNT_W'(DEPTH));

  // clear outranks every other request, including a write in the same cycle
  assign wr_go    = bus.in_valid && bus.in_ready && !bus.clear;
  assign count_nx = count_q + CNT_W'(wr_go);
  assign start_go = bus.start && !bus.clear && (state_q != PLAY) && (count_nx != '0);
  assign pick_go  = bus.pick && !bus.clear && (state_q == PLAY);
  assign wrap     = (CNT_W'(rd_ptr_q) == count_q - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear)    state_d = IDLE;
    else if (start_go) state_d = PLAY;
    else if (wr_go)    state_d = LOAD;
  end

  // draft storage is data only; stale rows stay unreachable once count is zeroed
  always_ff @(posedge clk) begin
    if (wr_go) mem[count_q[IDX_W-1:0]] <= bus.in_data;
  end

  // stage p0: playback pointer, repeat tracking and registered row outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      rot_q      <= '0;
      repeat_q   <= '0;
      row_out_p0 <= '0;
      row_idx_p0 <= '0;
      vld_p0     <= 1'b0;
    end else if (bus.clear) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      rot_q      <= '0;
      repeat_q   <= '0;
      row_out_p0 <= '0;
      row_idx_p0 <= '0;
      vld_p0     <= 1'b0;
    end else begin
      count_q <= count_nx;
      vld_p0  <= pick_go;
      if (start_go) begin
        rd_ptr_q <= '0;
        repeat_q <= '0;
        rot_q    <= '0;
      end else if (pick_go) begin
        row_out_p0 <= rotl(mem[rd_ptr_q], rot_q);
        row_idx_p0 <= rd_ptr_q;
        if (wrap) begin
          rd_ptr_q <= '0;
          repeat_q <= sat_inc(repeat_q);
`ifdef WEAVE_TWILL_SHIFT_EN
          rot_q    <= rot_next(rot_q);
`endif
        end else begin
          rd_ptr_q <= rd_ptr_q + IDX_W'(1);
        end
      end
    end
  end

  assign bus.row_out    = row_out_p0;
  assign bus.row_idx    = row_idx_p0;
  assign bus.row_valid  = vld_p0;
  assign bus.repeat_cnt = repeat_q;
  assign bus.playing    = (state_q == PLAY);

endmodule

// File: doc/weave_row_sequencer.md
# weave_row_sequencer

Draft-row sequencer sitting directly downstream of the weaving top's 8-bit pattern word output. It captures up to DEPTH lift rows (one bit per warp thread) over a valid/ready handshake, then replays them cyclically, one row per pick request, to drive the shed outputs. An optional twill mode rotates the pattern by one thread on every repeat.

## Interface
- DEPTH, 8, number of stored rows; power of two, 2..16
- W, 8, row width in warp threads
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  W  lift row to store
- in_valid  in  1  in_data valid
- in_ready  out  1  row accepted when in_valid && in_ready at clk edge
- start  in  1  one-cycle pulse: begin playback
- clear  in  1  one-cycle pulse: discard draft, return to IDLE
- pick  in  1  one-cycle pulse: request next row (PLAY only)
- row_out  out  W  current lift row, registered
- row_valid  out  1  high exactly one cycle per served pick
- row_idx  out  $clog2(DEPTH)  index of row currently on row_out
- repeat_cnt  out  8  completed draft repeats, saturates at 255
- playing  out  1  high in PLAY

## Operation
- States: IDLE (count==0), LOAD (0<count<=DEPTH, not playing), PLAY.
- in_ready = (state != PLAY) && (count < DEPTH); combinational.
- Accepted write: mem[count] <= in_data, count++; IDLE -> LOAD on first write.
- count == DEPTH: in_ready low; further in_valid ignored, no overwrite.
- start in LOAD -> PLAY; rd_ptr=0, repeat_cnt=0, rot=0. start in IDLE or PLAY ignored.
- start and accepted write in same LOAD/IDLE cycle: write lands, count includes it; PLAY entered only if resulting count>0 (an IDLE write+start enters PLAY with count 1).
- pick in PLAY: row_out <= rotl(mem[rd_ptr], rot), row_idx <= rd_ptr, row_valid <= 1. rd_ptr wraps to 0 after count-1; on wrap repeat_cnt++ (sat 255) and rot <= (rot+1) mod W when twill enabled.
- pick outside PLAY: ignored, row_valid stays 0.
- clear: highest priority over start/pick/write. Next state IDLE, count=0, rd_ptr=0, rot=0, repeat_cnt=0, row_out=0, row_idx=0, row_valid=0. mem contents not cleared (unreadable until rewritten).
- Draft contents frozen during PLAY; no writes accepted.

## Timing
- Reset values: row_out=0, row_valid=0, row_idx=0, repeat_cnt=0, playing=0; in_ready=1 (IDLE, count 0).
- Write throughput: one row per cycle while in_ready.
- start at edge N: playing=1 after edge N; first pick accepted at edge N+1 earliest.
- Pick latency: pick sampled at edge N -> row_out/row_idx/row_valid updated after edge N, row_valid falls after edge N+1 unless another pick.
- Back-to-back picks every cycle supported; row_valid stays high, row_out advances each cycle.
- row_out holds last value between picks.
- rst mid-operation: immediate return to reset values; no partial write committed.

## Configuration
- WEAVE_TWILL_SHIFT_EN defined: rot advances by 1 (mod W) on each rd_ptr wrap; row_out = mem rotated left by rot.
- Undefined: rot tied to 0; row_out = mem[rd_ptr] unchanged on every repeat; all other behaviour identical.

## Test plan
- Reset: assert rst mid-PLAY -> row_out=0, row_valid=0, repeat_cnt=0, playing=0, in_ready=1.
- Load 3 rows 0x81,0x42,0x24, start, 7 picks -> row_out 0x81,0x42,0x24,0x81,0x42,0x24,0x81; row_idx 0,1,2,0,1,2,0; repeat_cnt 2 after picks; twill macro off.
- Twill on, load 0x01,0x03, start, 6 picks -> 0x01,0x03,0x02,0x06,0x04,0x0C.
- Full: DEPTH=8, offer 10 rows 0x10..0x19 continuously -> in_ready falls after 8th; playback returns 0x10..0x17 only.
- Edge events: start with count 0 -> stays IDLE; pick in LOAD -> no row_valid; clear+pick same cycle in PLAY -> IDLE, row_valid 0, row_out 0.
- Saturation: 1-row draft, 300 picks -> repeat_cnt sticks at 255, row_valid high each served pick.
